// File: rtl/leg_alu_pkg.sv
// Shared definitions for the LEG ALU arbiter: data width, opcode values and FSM encoding.
package leg_alu_pkg;

  localparam int LEG_DATA_W = 8;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_SUB  = 8'd1;
  localparam logic [7:0] OP_AND  = 8'd2;
  localparam logic [7:0] OP_OR   = 8'd3;
  localparam logic [7:0] OP_NOT  = 8'd4;
  localparam logic [7:0] OP_XOR  = 8'd5;
  localparam logic [7:0] OP_SHL  = 8'd6;
  localparam logic [7:0] OP_ASHR = 8'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/leg_alu_arbiter_if.sv
// Requester and response channel bundle for leg_alu_arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface leg_alu_arbiter_if #(parameter int NREQ = 2);
  import leg_alu_pkg::*;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [LEG_DATA_W*NREQ-1:0] req_a;
  logic [LEG_DATA_W*NREQ-1:0] req_b;
  logic [LEG_DATA_W*NREQ-1:0] req_op;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [LEG_DATA_W-1:0]      rsp_data;
  logic [1:0]                 rsp_id;
  logic                       rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/leg_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr_i, with wrap.
module leg_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [1:0]      gnt_idx_o
);

  always_comb begin
    int  idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/leg_alu_arbiter.sv
// Shares one external combinational LEG ALU among NREQ requesters with a registered result channel.
// Optional opcode check enabled by defining LEG_ALU_ARB_OPCHK_EN.
//   state   | meaning
//   ST_IDLE | waiting for a request
//   ST_EXEC | ALU driven from latched operands, result captured
//   ST_RESP | result presented until rsp_ready
module leg_alu_arbiter
  import leg_alu_pkg::*;
#(
  parameter int    NREQ = 2,
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  leg_alu_arbiter_if.slave      bus,
  output logic [LEG_DATA_W-1:0] alu_in1_o,
  output logic [LEG_DATA_W-1:0] alu_in2_o,
  output logic [LEG_DATA_W-1:0] alu_op_o,
  input  logic [LEG_DATA_W-1:0] alu_out_i
);

  state_t                state_q;
  logic [1:0]            rr_ptr_q;
  logic [LEG_DATA_W-1:0] a_q, b_q, op_q;
  logic [1:0]            id_q;
  logic                  rsp_valid_q;
  logic [LEG_DATA_W-1:0] rsp_data_q;
  logic [1:0]            rsp_id_q;
  logic                  rsp_err_q;

  logic [NREQ-1:0]       gnt;
  logic [1:0]            gnt_idx;
  logic                  accept_en;
  logic                  accept;
  logic [LEG_DATA_W-1:0] a_d, b_d, op_d;
  logic                  op_illegal;
  logic                  unused_cfg;

  assign accept_en = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);

  leg_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .en_i      (accept_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  assign a_d  = bus.req_a [{gnt_idx, 3'b000} +: LEG_DATA_W];
  assign b_d  = bus.req_b [{gnt_idx, 3'b000} +: LEG_DATA_W];
  assign op_d = bus.req_op[{gnt_idx, 3'b000} +: LEG_DATA_W];

`ifdef LEG_ALU_ARB_OPCHK_EN
  // Out-of-range opcodes still spend EXEC so latency stays fixed.
  assign op_illegal = |op_q[7:3];
  assign alu_op_o   = op_q;
  assign unused_cfg = (UUID != 0) || (NAME != "");
`else
  assign op_illegal = 1'b0;
  assign alu_op_o   = {5'b0, op_q[2:0]};
  assign unused_cfg = (UUID != 0) || (NAME != "") || (|op_q[7:3]);
`endif

  assign alu_in1_o = a_q;
  assign alu_in2_o = b_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (state_q == ST_IDLE || bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            if (accept) begin
              a_q      <= a_d;
              b_q      <= b_d;
              op_q     <= op_d;
              id_q     <= gnt_idx;
              rr_ptr_q <= gnt_idx;
              state_q  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= op_illegal ? '0 : alu_out_i;
          rsp_err_q   <= op_illegal;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_alu_arbiter.sv
// Directed self-checking bench for leg_alu_arbiter with a behavioural LEG ALU attached.
module tb_leg_alu_arbiter;
  import leg_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_in1, alu_in2, alu_op, alu_out;
  int         errors = 0;
  int         checks = 0;

  leg_alu_arbiter_if #(.NREQ(2)) bus ();

  leg_alu_arbiter #(.NREQ(2), .UUID(0), .NAME("arb0")) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_in1_o (alu_in1),
    .alu_in2_o (alu_in2),
    .alu_op_o  (alu_op),
    .alu_out_i (alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      OP_NOT:  alu_out = ~alu_in1;
      OP_XOR:  alu_out = alu_in1 ^ alu_in2;
      OP_SHL:  alu_out = alu_in1 << alu_in2;
      OP_ASHR: alu_out = 8'($signed(alu_in1) >>> alu_in2);
      default: alu_out = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    bus.req_a [8*idx +: 8] = a;
    bus.req_b [8*idx +: 8] = b;
    bus.req_op[8*idx +: 8] = op;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("rst_alu_in1",   32'(alu_in1),       32'h0);
    chk("rst_alu_op",    32'(alu_op),        32'h0);

    // 1: ADD 5+3, latency 2
    set_req(0, 8'h05, 8'h03, OP_ADD);
    bus.req_valid = 2'b01;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("t1_exec_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_alu_in1",    32'(alu_in1),       32'h05);
    chk("t1_alu_in2",    32'(alu_in2),       32'h03);
    tick();
    chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_data",  32'(bus.rsp_data),  32'h08);
    chk("t1_id",    32'(bus.rsp_id),    32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_done", 32'(bus.rsp_valid), 32'h0);

    // 2: simultaneous requests after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 8'h03, 8'h05, OP_SUB);
    set_req(1, 8'hF0, 8'h3C, OP_AND);
    bus.req_valid = 2'b11;
    #1;
    chk("t2_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    #1;
    chk("t2_exec_noready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("t2_data0",  32'(bus.rsp_data),  32'hFE);
    chk("t2_id0",    32'(bus.rsp_id),    32'h0);
    chk("t2_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t2_valid1", 32'(bus.rsp_valid), 32'h1);
    chk("t2_data1",  32'(bus.rsp_data),  32'h30);
    chk("t2_id1",    32'(bus.rsp_id),    32'h1);
    tick();

    // 3: both held valid, grants alternate, one op per 2 cycles
    set_req(0, 8'h10, 8'h01, OP_ADD);
    set_req(1, 8'h20, 8'h02, OP_ADD);
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("t3_exec_valid", 32'(bus.rsp_valid), 32'h0);
      tick();
      chk("t3_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t3_id",    32'(bus.rsp_id),    32'(i % 2));
      chk("t3_data",  32'(bus.rsp_data),  (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    bus.req_valid = 2'b00;
    tick();

    // 4: ASHR 0x80>>>1 held under backpressure
    bus.rsp_ready = 1'b0;
    set_req(0, 8'h80, 8'h01, OP_ASHR);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t4_data",  32'(bus.rsp_data),  32'hC0);
      chk("t4_noacc", 32'(bus.req_ready), 32'h0);
      chk("t4_alu_hold", 32'(alu_in1),    32'h80);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_release", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    chk("t4_exec_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t4_data1", 32'(bus.rsp_data), 32'h22);
    chk("t4_id1",   32'(bus.rsp_id),   32'h1);
    tick();

    // 5: reset during EXEC discards the op
    set_req(0, 8'h01, 8'h03, OP_SHL);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
      tick();
    end
    chk("t5_alu_cleared", 32'(alu_in1), 32'h0);
    set_req(0, 8'h01, 8'h01, OP_ADD);
    set_req(1, 8'h40, 8'h01, OP_ADD);
    bus.req_valid = 2'b11;
    #1;
    chk("t5_ptr_reinit", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t5_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t5_data",  32'(bus.rsp_data),  32'h02);
    chk("t5_id",    32'(bus.rsp_id),    32'h0);
    tick();

    // 6: opcode 0x09
    set_req(0, 8'h05, 8'h03, 8'h09);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("t6_exec_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("t6_valid", 32'(bus.rsp_valid), 32'h1);
`ifdef LEG_ALU_ARB_OPCHK_EN
    chk("t6_data", 32'(bus.rsp_data), 32'h00);
    chk("t6_err",  32'(bus.rsp_err),  32'h1);
`else
    chk("t6_data", 32'(bus.rsp_data), 32'h02);
    chk("t6_err",  32'(bus.rsp_err),  32'h0);
`endif
    tick();
    chk("t6_idle", 32'(bus.rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
